// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
//
// Main control unit for a multicycle MIPS-style datapath that uses one unified
// memory for instructions and data. One instruction moves through a short
// sequence of states. Every datapath control output is decoded combinationally
// from the current state, the opcode/function fields and the memory handshake.
// The only exception is pc_en, which also folds in the ALU zero flag to gate
// a taken branch.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-high reset (forces FETCH)
//   op[5:0]      opcode field of the instruction register
//   funct[5:0]   function field of the instruction register (R-type)
//   zero         ALU zero flag
//   mem_ready    unified memory completed the current access this cycle
//   iord         memory address select: 0 = PC, 1 = ALU out register
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   ir_write     instruction register load enable
//   reg_write    register file write enable
//   reg_dst      register file destination select: 1 = rd, 0 = rt
//   mem_to_reg   register file write data select: 1 = memory data
//   alu_src_a    ALU A select: 0 = PC, 1 = A register
//   alu_src_b    ALU B select: 00 = B, 01 = 4, 10 = signImm, 11 = signImm<<2
//   alu_control  ALU operation code
//   pc_src       PC source: 00 = ALU result, 01 = ALU out, 10 = jump target
//   pc_en        PC load enable
//   state[3:0]   current state code
//   instr_done   one-cycle pulse in the last cycle of every instruction
//   illegal      one-cycle pulse on an unsupported opcode or function
// -----------------------------------------------------------------------------
module mc_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   state_t state_q;
   state_t state_nxt;
   logic   pc_write;
   logic   branch;

   // R-type function decode: returns {supported, alu_control}.
   function automatic logic [3:0] decode_funct(input logic [5:0] f);
      logic [3:0] r;
      case (f)
         6'b100000: r = {1'b1, ALU_ADD};
         6'b100010: r = {1'b1, ALU_SUB};
         6'b100100: r = {1'b1, ALU_AND};
         6'b100101: r = {1'b1, ALU_OR};
         6'b101010: r = {1'b1, ALU_SLT};
         default:   r = {1'b0, ALU_AND};
      endcase
      return r;
   endfunction

   // State register; reset aborts any instruction in flight, memory waits included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      logic [3:0] fdec;

      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_control = ALU_AND;
      pc_src      = PCSRC_ALU;
      pc_write    = 1'b0;
      branch      = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      state_nxt   = S_FETCH;
      fdec        = decode_funct(funct);

      case (state_q)
         S_FETCH: begin
            // PC + 4 is computed every fetch cycle but only committed with the
            // instruction word, so a wait cycle leaves every output unchanged.
            mem_read    = 1'b1;
            alu_src_b   = SRCB_FOUR;
            alu_control = ALU_ADD;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end else begin
               state_nxt = S_FETCH;
            end
         end

         S_DECODE: begin
            // Speculatively form the branch target in the ALU out register.
            alu_src_b   = SRCB_IMMSH;
            alu_control = ALU_ADD;
            case (op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXECUTE;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEXEC;
               OP_J:         state_nxt = S_JUMP;
               default: begin
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end

         S_MEMADR: begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
            state_nxt   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end

         S_MEMREAD: begin
            iord      = 1'b1;
            mem_read  = 1'b1;
            state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
         end

         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_MEMWRITE: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            state_nxt  = mem_ready ? S_FETCH : S_MEMWRITE;
         end

         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_REG;
            if (fdec[3]) begin
               alu_control = fdec[2:0];
               state_nxt   = S_ALUWB;
            end else begin
               illegal   = 1'b1;
               state_nxt = S_FETCH;
            end
         end

         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRCB_REG;
            alu_control = ALU_SUB;
            pc_src      = PCSRC_ALUOUT;
            branch      = 1'b1;
            instr_done  = 1'b1;
            state_nxt   = S_FETCH;
         end

         S_ADDIEXEC: begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
            state_nxt   = S_ADDIWB;
         end

         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         // Unused codes 12-15 drive nothing and recover to FETCH.
         default: state_nxt = S_FETCH;
      endcase
   end

   assign pc_en = pc_write | (branch & zero);
   assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       iord, mem_read, mem_write, ir_write;
   logic       reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] pc_src;
   logic       pc_en;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal;

   int total = 0;
   int bad   = 0;

   mc_control dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_control(alu_control),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .state      (state),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fetch with zero-wait memory, leaves the FSM in DECODE.
   task automatic do_fetch(input string tag);
      mem_ready = 1'b1;
      #1;
      chk({tag, " fetch state"}, state, 0);
      chk({tag, " fetch ir_write"}, ir_write, 1);
      chk({tag, " fetch pc_en"}, pc_en, 1);
      step();
      chk({tag, " decode state"}, state, 1);
   endtask

   initial begin
      rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      // Reset: FETCH decode, no writes, nothing illegal.
      chk("rst state", state, 0);
      chk("rst mem_read", mem_read, 1);
      chk("rst alu_src_b", alu_src_b, 2'b01);
      chk("rst alu_control", alu_control, 3'b010);
      chk("rst mem_write", mem_write, 0);
      chk("rst reg_write", reg_write, 0);
      chk("rst illegal", illegal, 0);
      step();
      step();
      rst = 1'b0;

      // FETCH wait: no IR/PC load, no progress.
      mem_ready = 1'b0;
      #1;
      chk("fwait ir_write", ir_write, 0);
      chk("fwait pc_en", pc_en, 0);
      chk("fwait mem_read", mem_read, 1);
      step();
      chk("fwait state", state, 0);

      // lw, zero wait: 0,1,2,3,4,0
      op = 6'b100011;
      do_fetch("lw");
      chk("lw decode alu_src_b", alu_src_b, 2'b11);
      chk("lw decode reg_write", reg_write, 0);
      step();
      chk("lw memadr state", state, 2);
      chk("lw memadr alu_src_a", alu_src_a, 1);
      chk("lw memadr alu_src_b", alu_src_b, 2'b10);
      step();
      chk("lw memread state", state, 3);
      chk("lw memread iord", iord, 1);
      chk("lw memread reg_write", reg_write, 0);
      chk("lw memread done", instr_done, 0);
      step();
      chk("lw memwb state", state, 4);
      chk("lw memwb reg_write", reg_write, 1);
      chk("lw memwb mem_to_reg", mem_to_reg, 1);
      chk("lw memwb reg_dst", reg_dst, 0);
      chk("lw memwb done", instr_done, 1);
      step();
      chk("lw end state", state, 0);
      chk("lw end reg_write", reg_write, 0);

      // sw with three wait cycles in MEMWRITE
      op = 6'b101011;
      do_fetch("sw");
      step();
      chk("sw memadr state", state, 2);
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("sw wait state", state, 5);
         chk("sw wait mem_write", mem_write, 1);
         chk("sw wait iord", iord, 1);
         chk("sw wait done", instr_done, 0);
         step();
      end
      mem_ready = 1'b1;
      #1;
      chk("sw ready state", state, 5);
      chk("sw ready mem_write", mem_write, 1);
      chk("sw ready iord", iord, 1);
      chk("sw ready done", instr_done, 1);
      step();
      chk("sw end state", state, 0);
      chk("sw end mem_write", mem_write, 0);

      // beq taken
      op = 6'b000100; zero = 1'b1;
      do_fetch("beqt");
      step();
      chk("beqt state", state, 8);
      chk("beqt pc_en", pc_en, 1);
      chk("beqt pc_src", pc_src, 2'b01);
      chk("beqt alu_control", alu_control, 3'b110);
      chk("beqt done", instr_done, 1);
      step();
      chk("beqt end state", state, 0);

      // beq not taken
      zero = 1'b0;
      do_fetch("beqn");
      step();
      chk("beqn state", state, 8);
      chk("beqn pc_en", pc_en, 0);
      chk("beqn pc_src", pc_src, 2'b01);
      step();
      chk("beqn end state", state, 0);

      // R-type slt
      op = 6'b000000; funct = 6'b101010;
      do_fetch("slt");
      step();
      chk("slt exec state", state, 6);
      chk("slt alu_control", alu_control, 3'b111);
      chk("slt alu_src_a", alu_src_a, 1);
      chk("slt alu_src_b", alu_src_b, 2'b00);
      chk("slt exec illegal", illegal, 0);
      step();
      chk("slt aluwb state", state, 7);
      chk("slt reg_dst", reg_dst, 1);
      chk("slt reg_write", reg_write, 1);
      chk("slt mem_to_reg", mem_to_reg, 0);
      chk("slt done", instr_done, 1);
      step();
      chk("slt end state", state, 0);

      // R-type sub: alu_control decode
      funct = 6'b100010;
      do_fetch("sub");
      step();
      chk("sub alu_control", alu_control, 3'b110);
      step();
      step();

      // R-type with unsupported funct
      funct = 6'b111111;
      do_fetch("badf");
      step();
      chk("badf state", state, 6);
      chk("badf illegal", illegal, 1);
      chk("badf reg_write", reg_write, 0);
      step();
      chk("badf next state", state, 0);
      chk("badf illegal clr", illegal, 0);
      chk("badf reg_write after", reg_write, 0);

      // Unsupported opcode
      op = 6'b111111;
      do_fetch("badop");
      chk("badop illegal", illegal, 1);
      chk("badop done", instr_done, 0);
      step();
      chk("badop next state", state, 0);
      chk("badop illegal clr", illegal, 0);

      // Jump
      op = 6'b000010;
      do_fetch("j");
      chk("j decode illegal", illegal, 0);
      step();
      chk("j state", state, 11);
      chk("j pc_src", pc_src, 2'b10);
      chk("j pc_en", pc_en, 1);
      chk("j done", instr_done, 1);
      step();
      chk("j end state", state, 0);

      // addi
      op = 6'b001000;
      do_fetch("addi");
      step();
      chk("addi exec state", state, 9);
      chk("addi alu_src_b", alu_src_b, 2'b10);
      chk("addi exec reg_write", reg_write, 0);
      step();
      chk("addi wb state", state, 10);
      chk("addi reg_write", reg_write, 1);
      chk("addi reg_dst", reg_dst, 0);
      chk("addi mem_to_reg", mem_to_reg, 0);
      chk("addi done", instr_done, 1);
      step();
      chk("addi end state", state, 0);

      // Reset during a MEMREAD wait
      op = 6'b100011;
      do_fetch("rstw");
      step();
      mem_ready = 1'b0;
      step();
      chk("rstw memread state", state, 3);
      rst = 1'b1;
      #1;
      chk("rstw async state", state, 0);
      chk("rstw reg_write", reg_write, 0);
      chk("rstw mem_write", mem_write, 0);
      mem_ready = 1'b1;
      step();
      chk("rstw held state", state, 0);
      chk("rstw held reg_write", reg_write, 0);
      rst = 1'b0;
      #1;
      chk("rstw release state", state, 0);
      chk("rstw release ir_write", ir_write, 1);
      step();
      chk("rstw resume state", state, 1);
      chk("rstw resume reg_write", reg_write, 0);
      step();
      chk("rstw resume memadr", state, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register.
REQ-005 funct  input  6  function field of the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  unified memory has completed the current access this cycle.
REQ-008 Memory control outputs, 1 bit each: iord (0 selects PC as memory address, 1 selects ALU out), mem_read, mem_write, ir_write.
REQ-009 Register-file control outputs, 1 bit each: reg_write, reg_dst (1 selects rd), mem_to_reg.
REQ-010 ALU control outputs: alu_src_a (1 bit; 0 = PC, 1 = A), alu_src_b (2 bits; 00 = B, 01 = const 4, 10 = signImm, 11 = signImm<<2), alu_control (3 bits).
REQ-011 PC control outputs: pc_src (2 bits; 00 = ALU result, 01 = ALU out register, 10 = jump target), pc_en (1 bit, PC load enable).
REQ-012 Status outputs: state (4 bits, current state), instr_done (1 bit), illegal (1 bit).

Function
REQ-013 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-014 Every output except pc_en SHALL be a combinational function of state, op, funct and mem_ready only; any output not listed for a state SHALL be 0.
REQ-015 pc_en SHALL equal pc_write | (branch & zero), where pc_write and branch are internal state decodes.
REQ-016 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
REQ-017 FETCH: ir_write and pc_write SHALL be 1 only in a cycle with mem_ready=1; go to DECODE when mem_ready=1, otherwise stay in FETCH.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (computes the branch target).
REQ-019 DECODE next state by op: 100011 or 101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP.
REQ-020 DECODE, any other op: illegal=1 for one cycle, next state FETCH.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010; next state MEMREAD if op=100011, else MEMWRITE.
REQ-022 MEMREAD: iord=1, mem_read=1; hold until mem_ready=1, then go to MEMWB.
REQ-023 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-024 MEMWRITE: iord=1, mem_write=1; hold until mem_ready=1, then go to FETCH.
REQ-025 EXECUTE: alu_src_a=1, alu_src_b=00, alu_control set by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-026 EXECUTE, any other funct: illegal=1, next state FETCH, no register write. Otherwise next state ALUWB.
REQ-027 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1; next state FETCH.
REQ-029 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_control=010; next state ADDIWB.
REQ-030 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-031 JUMP: pc_src=10, pc_write=1; next state FETCH.
REQ-032 instr_done SHALL be 1 for exactly one cycle in each of these terminal cycles: MEMWB, MEMWRITE with mem_ready=1, ALUWB, BRANCH, ADDIWB, JUMP.
REQ-033 Cycle counts with zero-wait memory (mem_ready tied to 1):
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
REQ-034 Each wait cycle (mem_ready=0 in FETCH, MEMREAD or MEMWRITE) SHALL add exactly one cycle and SHALL NOT change any output.

Reset
REQ-035 While rst=1, state SHALL be FETCH, independent of clk.
REQ-036 With rst=1, outputs SHALL equal the FETCH decode; mem_write=0, reg_write=0 and illegal=0 are guaranteed.
REQ-037 Reset asserted mid-instruction (including during a memory wait) SHALL abort the instruction with no further writes; fetch restarts on the first clock edge after rst deasserts.

Verification
REQ-038 lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done in cycle 5.
REQ-039 sw, mem_ready=0 for 3 cycles in MEMWRITE -> mem_write=1 and iord=1 held for 4 cycles; instr_done only in the cycle where mem_ready=1.
REQ-040 beq with zero=1 -> pc_en=1 in BRANCH with pc_src=01. Same instruction with zero=0 -> pc_en=0 in BRANCH.
REQ-041 R-type with funct=101010 -> alu_control=111 in EXECUTE and reg_dst=1 in ALUWB. Repeat with funct=111111 -> illegal pulse, next state FETCH, reg_write never asserted.
REQ-042 op=111111 in DECODE -> illegal=1 for one cycle, then FETCH; j (op=000010) -> pc_src=10 and pc_en=1 in JUMP.
REQ-043 rst pulsed during a MEMREAD wait -> state=0 immediately; no reg_write afterwards; normal fetch resumes after release.
